// File: rtl/dual_ad7528_atten_if.sv
// Serial gain-programming bus and stereo PCM path of the CD-i attenuation matrix.
// The master side is the slave uC plus CDIC; the slave side is the DAC emulation.
interface dual_ad7528_atten_if;
    logic               datadac;
    logic               clkdac;
    logic               csdac1n;
    logic               csdac2n;
    logic signed [15:0] audio_left_in;
    logic signed [15:0] audio_right_in;
    logic signed [15:0] audio_left_out;
    logic signed [15:0] audio_right_out;

    modport master (
        output datadac, clkdac, csdac1n, csdac2n, audio_left_in, audio_right_in,
        input  audio_left_out, audio_right_out
    );

    modport slave (
        input  datadac, clkdac, csdac1n, csdac2n, audio_left_in, audio_right_in,
        output audio_left_out, audio_right_out
    );
endinterface

// File: rtl/dual_ad7528_atten.sv
// Emulation of the two AD7528 dual multiplying DACs: a 3-wire serial gain loader
// feeding a registered 2x2 mixing matrix with saturation to 16-bit signed.
module dual_ad7528_atten (
    input logic                 clk,
    input logic                 reset_n,
    dual_ad7528_atten_if.slave  bus
);
    logic       clkdac_q;
    logic       cs1_q;
    logic       cs2_q;
    logic [8:0] shreg;
    logic [3:0] bit_cnt;
    logic [7:0] gain_ll;
    logic [7:0] gain_rl;
    logic [7:0] gain_rr;
    logic [7:0] gain_lr;

    logic clk_rise;
    logic cs1_rise;
    logic cs1_fall;
    logic cs2_rise;
    logic cs2_fall;
    logic shift_en;
    logic frame_ok;
    logic latch1;
    logic latch2;

    assign clk_rise = bus.clkdac & ~clkdac_q;
    assign cs1_rise = bus.csdac1n & ~cs1_q;
    assign cs1_fall = ~bus.csdac1n & cs1_q;
    assign cs2_rise = bus.csdac2n & ~cs2_q;
    assign cs2_fall = ~bus.csdac2n & cs2_q;
    // A chip select that is high right now blocks the shift even if it just rose.
    assign shift_en = clk_rise & (~bus.csdac1n | ~bus.csdac2n);
    assign frame_ok = (bit_cnt >= 4'd9);
    assign latch1   = cs1_rise & frame_ok;
    assign latch2   = cs2_rise & frame_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clkdac_q <= 1'b0;
            cs1_q    <= 1'b1;
            cs2_q    <= 1'b1;
            shreg    <= 9'd0;
            bit_cnt  <= 4'd0;
        end else begin
            clkdac_q <= bus.clkdac;
            cs1_q    <= bus.csdac1n;
            cs2_q    <= bus.csdac2n;
            if (shift_en)
                shreg <= {shreg[7:0], bus.datadac};
            if (cs1_fall || cs2_fall)
                bit_cnt <= shift_en ? 4'd1 : 4'd0;
            else if (shift_en && bit_cnt != 4'd9)
                bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // shreg here is the pre-shift value, so a same-cycle clkdac edge cannot corrupt the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gain_ll <= 8'hFF;
            gain_rl <= 8'h00;
            gain_rr <= 8'hFF;
            gain_lr <= 8'h00;
        end else begin
            if (latch1) begin
                if (shreg[8]) gain_rl <= shreg[7:0];
                else          gain_ll <= shreg[7:0];
            end
            if (latch2) begin
                if (shreg[8]) gain_lr <= shreg[7:0];
                else          gain_rr <= shreg[7:0];
            end
        end
    end

    function automatic logic signed [24:0] scale(input logic signed [15:0] s,
                                                 input logic [7:0] g);
        return $signed({{9{s[15]}}, s}) * $signed({17'd0, g});
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
        if (v > 26'sd32767)
            return 16'sh7FFF;
        else if (v < -26'sd32768)
            return 16'sh8000;
        return v[15:0];
    endfunction

    logic signed [24:0] p_ll;
    logic signed [24:0] p_rl;
    logic signed [24:0] p_rr;
    logic signed [24:0] p_lr;
    logic signed [25:0] sum_l;
    logic signed [25:0] sum_r;
    logic signed [25:0] shr_l;
    logic signed [25:0] shr_r;

    assign p_ll  = scale(bus.audio_left_in,  gain_ll);
    assign p_rl  = scale(bus.audio_right_in, gain_rl);
    assign p_rr  = scale(bus.audio_right_in, gain_rr);
    assign p_lr  = scale(bus.audio_left_in,  gain_lr);
    assign sum_l = $signed({p_ll[24], p_ll}) + $signed({p_rl[24], p_rl});
    assign sum_r = $signed({p_rr[24], p_rr}) + $signed({p_lr[24], p_lr});
    assign shr_l = sum_l >>> 8;
    assign shr_r = sum_r >>> 8;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.audio_left_out  <= 16'sd0;
            bus.audio_right_out <= 16'sd0;
        end else begin
            bus.audio_left_out  <= sat16(shr_l);
            bus.audio_right_out <= sat16(shr_r);
        end
    end
endmodule

// File: tb/tb_dual_ad7528_atten.sv
// Randomized scoreboard bench for dual_ad7528_atten against an arithmetic gain/mix model.
module tb_dual_ad7528_atten;
    logic clk;
    logic reset_n;
    dual_ad7528_atten_if bus ();

    dual_ad7528_atten dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int     l;
        int     r;
        longint due;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     total = 0;
    int     bad = 0;
    int     g_ll, g_rl, g_rr, g_lr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int floor256(input longint v);
        longint q;
        q = v / 256;
        if (v < 0 && (v % 256) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic model_reset();
        g_ll = 255; g_rr = 255; g_rl = 0; g_lr = 0;
    endtask

    // Monitor: outputs are valid every cycle; check each expectation once its cycle arrives.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            int al, ar;
            e  = sb.pop_front();
            al = int'($signed(bus.audio_left_out));
            ar = int'($signed(bus.audio_right_out));
            total++;
            if (al != e.l) begin
                bad++;
                $display("FAIL left: got %0d want %0d (cycle %0d)", al, e.l, cyc);
            end
            total++;
            if (ar != e.r) begin
                bad++;
                $display("FAIL right: got %0d want %0d (cycle %0d)", ar, e.r, cyc);
            end
        end
    end

    task automatic apply_audio(input int l, input int r);
        exp_t e;
        @(negedge clk);
        bus.audio_left_in  = 16'(l);
        bus.audio_right_in = 16'(r);
        e.l   = floor256(longint'(l) * g_ll + longint'(r) * g_rl);
        e.r   = floor256(longint'(r) * g_rr + longint'(l) * g_lr);
        e.due = cyc + 1;
        sb.push_back(e);
    endtask

    // Sends the low n bits of word, oldest first; the model keeps only the last 9.
    task automatic send_frame(input bit use1, input bit use2, input logic [15:0] word, input int n);
        logic [8:0] last9;
        @(negedge clk);
        bus.csdac1n = ~use1;
        bus.csdac2n = ~use2;
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            bus.datadac = word[i];
            bus.clkdac  = 1'b0;
            @(negedge clk);
            bus.clkdac  = 1'b1;
        end
        @(negedge clk);
        bus.clkdac  = 1'b0;
        @(negedge clk);
        bus.csdac1n = 1'b1;
        bus.csdac2n = 1'b1;
        @(negedge clk);
        last9 = word[8:0];
        if (n >= 9) begin
            if (use1) begin
                if (last9[8]) g_rl = int'(last9[7:0]);
                else          g_ll = int'(last9[7:0]);
            end
            if (use2) begin
                if (last9[8]) g_lr = int'(last9[7:0]);
                else          g_rr = int'(last9[7:0]);
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        total++;
        if (bus.audio_left_out !== 16'sd0 || bus.audio_right_out !== 16'sd0) begin
            bad++;
            $display("FAIL %s: got %0d/%0d want 0/0", name,
                     $signed(bus.audio_left_out), $signed(bus.audio_right_out));
        end
    endtask

    initial begin
        int l, r, n, kind;
        logic [15:0] w;
        bit u1, u2;

        reset_n            = 1'b0;
        bus.datadac        = 1'b0;
        bus.clkdac         = 1'b0;
        bus.csdac1n        = 1'b1;
        bus.csdac2n        = 1'b1;
        bus.audio_left_in  = 16'sd1000;
        bus.audio_right_in = 16'sd1000;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_outputs");
        reset_n = 1'b1;

        apply_audio(1000, -2000);
        apply_audio(0, 0);

        send_frame(1, 0, 16'h080, 9);
        apply_audio(1000, 0);

        send_frame(0, 1, 16'h1FF, 9);
        apply_audio(256, 0);

        send_frame(1, 0, 16'h0FF, 9);
        send_frame(1, 0, 16'h1FF, 9);
        apply_audio(32767, 32767);
        apply_audio(-32768, -32768);
        apply_audio(-1, 0);

        send_frame(1, 0, 16'h013, 5);
        apply_audio(1000, 0);
        send_frame(1, 0, 16'hA_C3 | 16'h0E00, 12);
        apply_audio(1000, 500);

        send_frame(1, 1, 16'h140, 9);
        apply_audio(0, 1024);
        apply_audio(-777, 1024);

        // Reset in the middle of a frame.
        @(negedge clk);
        bus.csdac1n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); bus.datadac = 1'b1; bus.clkdac = 1'b0;
            @(negedge clk); bus.clkdac = 1'b1;
        end
        @(negedge clk);
        reset_n     = 1'b0;
        bus.clkdac  = 1'b0;
        bus.csdac1n = 1'b1;
        model_reset();
        @(negedge clk);
        check_zero_outputs("midframe_reset_outputs");
        reset_n = 1'b1;
        apply_audio(1000, -2000);
        send_frame(1, 0, 16'h040, 9);
        apply_audio(4000, 0);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            if (kind != 0) begin
                u1 = 1'($urandom_range(0, 1));
                u2 = 1'($urandom_range(0, 1));
                if (!u1 && !u2) u1 = 1'b1;
                w = 16'($urandom);
                n = $urandom_range(3, 13);
                send_frame(u1, u2, w, n);
            end
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    l = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
                    r = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
                end else begin
                    l = int'($urandom_range(0, 65535)) - 32768;
                    r = int'($urandom_range(0, 65535)) - 32768;
                end
                apply_audio(l, r);
            end
        end

        for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
